audio_sched: RTL and testbench

Shares the board's single tone path (tone PWM generator plus amplifier enable) among three sound sources: looping background music, a one-shot effect and a one-shot alarm. Each sound is a fixed note sequence stored internally, one note per beat; the beat timer is derived from the system clock. Arbitration is fixed-priority and preemptive: background music resumes where it was interrupted, and preempted one-shots are dropped. The block sits between game control logic and the tone PWM generator; `freq` drives the generator's frequency input and `amp_en` drives pmod_4.

---
 rtl/audio_sched.sv | 202 ++++++++++++++++++++
 tb/tb_audio_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sched.sv
// audio_sched: shares one tone path (PWM frequency + amplifier enable) between
// looping background music (id 0), a one-shot effect (id 1) and a one-shot
// alarm (id 2) with fixed-priority preemptive arbitration.
module audio_sched #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic        mute,
  output logic [31:0] freq,
  output logic        amp_en,
  output logic        busy,
  output logic [1:0]  cur_id,
  output logic [3:0]  note_idx,
  output logic        done
);

  localparam int DIV   = CLK_HZ / BEAT_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] ID_BG   = 2'd0;
  localparam logic [1:0] ID_NONE = 2'd3;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state, state_n;
  logic [1:0]       cur_id_n;
  logic [3:0]       note_idx_n;
  logic [3:0]       saved_idx, saved_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       pend, pend_n;
  logic             done_n;
  logic [31:0]      freq_n;
  logic             amp_en_n;
  logic             tick;
  logic             grant;
  logic             win_vld;
  logic [1:0]       win_id;

  // Note frequency table; rests are encoded as 0 Hz.
  function automatic logic [31:0] rom_freq(input logic [1:0] id, input logic [3:0] idx);
    logic [31:0] f;
    f = 32'd0;
    case (id)
      2'd0: begin
        case (idx)
          4'd0:  f = 32'd262;
          4'd1:  f = 32'd294;
          4'd2:  f = 32'd330;
          4'd3:  f = 32'd349;
          4'd4:  f = 32'd392;
          4'd5:  f = 32'd440;
          4'd6:  f = 32'd494;
          4'd7:  f = 32'd523;
          4'd8:  f = 32'd523;
          4'd9:  f = 32'd494;
          4'd10: f = 32'd440;
          4'd11: f = 32'd392;
          4'd12: f = 32'd349;
          4'd13: f = 32'd330;
          4'd14: f = 32'd294;
          default: f = 32'd262;
        endcase
      end
      2'd1: begin
        case (idx)
          4'd0:    f = 32'd523;
          4'd1:    f = 32'd659;
          4'd2:    f = 32'd784;
          4'd3:    f = 32'd1047;
          default: f = 32'd0;
        endcase
      end
      2'd2: begin
        // Alarm alternates tone and rest on every beat.
        f = (idx <= 4'd7 && !idx[0]) ? 32'd880 : 32'd0;
      end
      default: f = 32'd0;
    endcase
    return f;
  endfunction

  // Index of the final note of each sequence.
  function automatic logic [3:0] last_idx(input logic [1:0] id);
    logic [3:0] l;
    case (id)
      2'd1:    l = 4'd3;
      2'd2:    l = 4'd7;
      default: l = 4'd15;
    endcase
    return l;
  endfunction

  assign busy = (state == PLAY);

  // Highest set pending bit wins: alarm over effect over background.
  always_comb begin
    win_vld = |pend;
    win_id  = ID_BG;
    if (pend[2])      win_id = 2'd2;
    else if (pend[1]) win_id = 2'd1;
  end

  // Sequencer next-state: note completion, stop, preemption and grant.
  always_comb begin
    state_n     = state;
    cur_id_n    = cur_id;
    note_idx_n  = note_idx;
    saved_idx_n = saved_idx;
    cnt_n       = cnt;
    done_n      = 1'b0;
    grant       = 1'b0;
    tick        = (state == PLAY) && (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (win_vld) grant = 1'b1;
      end
      PLAY: begin
        if (tick && cur_id != ID_BG && note_idx == last_idx(cur_id)) begin
          // One-shot finished normally; hand over without an idle cycle.
          done_n     = 1'b1;
          state_n    = IDLE;
          cur_id_n   = ID_NONE;
          note_idx_n = 4'd0;
          cnt_n      = '0;
          if (win_vld) grant = 1'b1;
        end else if (tick && cur_id == ID_BG && !pend[0]) begin
          // Background released: the note has just finished, forget the position.
          saved_idx_n = 4'd0;
          state_n     = IDLE;
          cur_id_n    = ID_NONE;
          note_idx_n  = 4'd0;
          cnt_n       = '0;
          if (win_vld) grant = 1'b1;
        end else if (win_vld && win_id > cur_id) begin
          // Preemption: background keeps its place, the effect is simply lost.
          if (cur_id == ID_BG) saved_idx_n = note_idx;
          grant = 1'b1;
        end else if (tick) begin
          cnt_n      = '0;
          note_idx_n = note_idx + 4'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Background not requested and not on air: resume point is discarded.
    if (!pend[0] && !(state == PLAY && cur_id == ID_BG)) saved_idx_n = 4'd0;

    if (grant) begin
      state_n    = PLAY;
      cur_id_n   = win_id;
      cnt_n      = '0;
      note_idx_n = (win_id == ID_BG) ? saved_idx_n : 4'd0;
    end

    // Pulse requests latch unless they target the sound now on air.
    pend_n[0] = req[0];
    for (int i = 1; i < 3; i++) begin
      pend_n[i] = (pend[i] && !(grant && win_id == 2'(i))) ||
                  (req[i] && !(state_n == PLAY && cur_id_n == 2'(i)));
    end

    freq_n   = (state_n == PLAY) ? rom_freq(cur_id_n, note_idx_n) : 32'd0;
    amp_en_n = (state_n == PLAY) && !mute;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cur_id    <= ID_NONE;
      note_idx  <= 4'd0;
      saved_idx <= 4'd0;
      cnt       <= '0;
      pend      <= 3'b000;
      done      <= 1'b0;
      freq      <= 32'd0;
      amp_en    <= 1'b0;
    end else begin
      state     <= state_n;
      cur_id    <= cur_id_n;
      note_idx  <= note_idx_n;
      saved_idx <= saved_idx_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      done      <= done_n;
      freq      <= freq_n;
      amp_en    <= amp_en_n;
    end
  end

endmodule

// File: tb/tb_audio_sched.sv
// Bench for audio_sched at CLK_HZ=80, BEAT_HZ=8 (10 cycles per note).
module tb_audio_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        mute;
  logic [31:0] freq;
  logic        amp_en;
  logic        busy;
  logic [1:0]  cur_id;
  logic [3:0]  note_idx;
  logic        done;

  audio_sched #(.CLK_HZ(80), .BEAT_HZ(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mute(mute),
    .freq(freq), .amp_en(amp_en), .busy(busy),
    .cur_id(cur_id), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  localparam int BG_F[16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                              523, 494, 440, 392, 349, 330, 294, 262};
  localparam int FX_F[4]  = '{523, 659, 784, 1047};

  typedef struct {
    logic [31:0] freq;
    logic        busy;
    logic [1:0]  id;
    logic [3:0]  idx;
    logic        done;
    logic        amp;
    string       tag;
  } exp_t;

  typedef struct {
    logic        rs;
    logic [2:0]  r;
    logic        m;
    int          n;
    logic [31:0] freq;
    logic        busy;
    logic [1:0]  id;
    logic [3:0]  idx;
    logic        done;
    logic        amp;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [31:0] ref_freq(input int id, input int idx);
    if (id == 0) return 32'(BG_F[idx]);
    if (id == 1) return 32'(FX_F[idx]);
    return (idx % 2 == 0) ? 32'd880 : 32'd0;
  endfunction

  task automatic push_note(input int id, input int idx, input int n,
                           input logic d, input logic amp, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.freq = ref_freq(id, idx);
      e.busy = 1'b1;
      e.id   = 2'(id);
      e.idx  = 4'(idx);
      e.done = (i == 0) ? d : 1'b0;
      e.amp  = amp;
      e.tag  = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n, input logic d, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.freq = 32'd0;
      e.busy = 1'b0;
      e.id   = 2'd3;
      e.idx  = 4'd0;
      e.done = (i == 0) ? d : 1'b0;
      e.amp  = 1'b0;
      e.tag  = tag;
      exp_q.push_back(e);
    end
  endtask

  // Drive inputs for n cycles; after each edge pop one expectation and compare.
  task automatic run(input int n, input logic [2:0] r, input logic m, input logic rs);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      req  = r;
      mute = m;
      rst  = rs;
      @(posedge clk);
      #1;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL underrun t=%0t: no expectation queued", $time);
      end else begin
        e = exp_q.pop_front();
        if ({freq, busy, cur_id, note_idx, done, amp_en} !==
            {e.freq, e.busy, e.id, e.idx, e.done, e.amp}) begin
          n_err++;
          $display("FAIL %s t=%0t: got freq=%0d busy=%0b id=%0d idx=%0d done=%0b amp=%0b, want freq=%0d busy=%0b id=%0d idx=%0d done=%0b amp=%0b",
                   e.tag, $time, freq, busy, cur_id, note_idx, done, amp_en,
                   e.freq, e.busy, e.id, e.idx, e.done, e.amp);
        end
      end
    end
  endtask

  task automatic add(input logic rs, input logic [2:0] r, input int n,
                     input logic [31:0] f, input logic b, input logic [1:0] id,
                     input logic [3:0] idx, input logic d);
    vec_t v;
    v.rs = rs; v.r = r; v.m = 1'b0; v.n = n;
    v.freq = f; v.busy = b; v.id = id; v.idx = idx; v.done = d; v.amp = b;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t e;
    rst  = 1'b0;
    req  = 3'b000;
    mute = 1'b0;

    // Vector table: reset, effect alone, simultaneous effect + alarm.
    add(1'b0, 3'b000, 2,  32'd0,    1'b0, 2'd3, 4'd0, 1'b0);
    add(1'b1, 3'b000, 3,  32'd0,    1'b0, 2'd3, 4'd0, 1'b0);
    add(1'b1, 3'b010, 1,  32'd0,    1'b0, 2'd3, 4'd0, 1'b0);
    add(1'b1, 3'b000, 10, 32'd523,  1'b1, 2'd1, 4'd0, 1'b0);
    add(1'b1, 3'b000, 10, 32'd659,  1'b1, 2'd1, 4'd1, 1'b0);
    add(1'b1, 3'b000, 10, 32'd784,  1'b1, 2'd1, 4'd2, 1'b0);
    add(1'b1, 3'b000, 10, 32'd1047, 1'b1, 2'd1, 4'd3, 1'b0);
    add(1'b1, 3'b000, 1,  32'd0,    1'b0, 2'd3, 4'd0, 1'b1);
    add(1'b1, 3'b000, 2,  32'd0,    1'b0, 2'd3, 4'd0, 1'b0);
    add(1'b1, 3'b110, 1,  32'd0,    1'b0, 2'd3, 4'd0, 1'b0);
    for (int a = 0; a < 8; a++)
      add(1'b1, 3'b000, 10, (a % 2 == 0) ? 32'd880 : 32'd0, 1'b1, 2'd2, 4'(a), 1'b0);
    add(1'b1, 3'b000, 1,  32'd523,  1'b1, 2'd1, 4'd0, 1'b1);
    add(1'b1, 3'b000, 9,  32'd523,  1'b1, 2'd1, 4'd0, 1'b0);
    add(1'b1, 3'b000, 10, 32'd659,  1'b1, 2'd1, 4'd1, 1'b0);
    add(1'b1, 3'b000, 10, 32'd784,  1'b1, 2'd1, 4'd2, 1'b0);
    add(1'b1, 3'b000, 10, 32'd1047, 1'b1, 2'd1, 4'd3, 1'b0);
    add(1'b1, 3'b000, 1,  32'd0,    1'b0, 2'd3, 4'd0, 1'b1);
    add(1'b1, 3'b000, 2,  32'd0,    1'b0, 2'd3, 4'd0, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      for (int c = 0; c < tbl[k].n; c++) begin
        e.freq = tbl[k].freq; e.busy = tbl[k].busy; e.id = tbl[k].id;
        e.idx = tbl[k].idx; e.done = tbl[k].done; e.amp = tbl[k].amp;
        e.tag = $sformatf("vec%0d", k);
        exp_q.push_back(e);
        run(1, tbl[k].r, tbl[k].m, tbl[k].rs);
      end
    end

    // Background loop with wrap, then release mid-note.
    push_idle(1, 1'b0, "bg_req");
    for (int i = 0; i < 16; i++) push_note(0, i, 10, 1'b0, 1'b1, "bg_loop");
    for (int i = 0; i < 3; i++)  push_note(0, i, 10, 1'b0, 1'b1, "bg_wrap");
    push_note(0, 3, 10, 1'b0, 1'b1, "bg_release_note");
    push_idle(3, 1'b0, "bg_stopped");
    run(1 + 160 + 30 + 4, 3'b001, 1'b0, 1'b1);
    run(6 + 3, 3'b000, 1'b0, 1'b1);

    // Alarm preempts background at note 5; background resumes note 5 in full.
    push_idle(1, 1'b0, "pre_req");
    for (int i = 0; i < 5; i++) push_note(0, i, 10, 1'b0, 1'b1, "pre_bg");
    push_note(0, 5, 3, 1'b0, 1'b1, "pre_bg5");
    for (int a = 0; a < 8; a++) push_note(2, a, 10, 1'b0, 1'b1, "pre_alarm");
    push_note(0, 5, 1, 1'b1, 1'b1, "resume_done");
    push_note(0, 5, 9, 1'b0, 1'b1, "resume_bg5");
    push_note(0, 6, 10, 1'b0, 1'b1, "resume_bg6");
    push_note(0, 7, 10, 1'b0, 1'b1, "resume_bg7");
    push_idle(2, 1'b0, "pre_end");
    run(1 + 50 + 2, 3'b001, 1'b0, 1'b1);
    run(1, 3'b101, 1'b0, 1'b1);
    run(80 + 10 + 10, 3'b001, 1'b0, 1'b1);
    run(12, 3'b000, 1'b0, 1'b1);

    // Effect re-request ignored, then effect preempted by alarm and dropped.
    push_idle(1, 1'b0, "drop_req");
    push_note(1, 0, 10, 1'b0, 1'b1, "drop_fx0");
    push_note(1, 1, 10, 1'b0, 1'b1, "drop_fx1");
    push_note(1, 2, 4, 1'b0, 1'b1, "drop_fx2");
    for (int a = 0; a < 8; a++) push_note(2, a, 10, 1'b0, 1'b1, "drop_alarm");
    push_idle(1, 1'b1, "drop_done");
    push_idle(3, 1'b0, "drop_idle");
    run(1, 3'b010, 1'b0, 1'b1);
    run(13, 3'b000, 1'b0, 1'b1);
    run(1, 3'b010, 1'b0, 1'b1);
    run(9, 3'b000, 1'b0, 1'b1);
    run(1, 3'b100, 1'b0, 1'b1);
    run(80 + 1 + 3, 3'b000, 1'b0, 1'b1);

    // Mute mid-effect: amplifier drops, sequence continues.
    push_idle(1, 1'b0, "mute_req");
    push_note(1, 0, 10, 1'b0, 1'b1, "mute_fx0");
    push_note(1, 1, 2, 1'b0, 1'b1, "mute_fx1_on");
    push_note(1, 1, 8, 1'b0, 1'b0, "mute_fx1_off");
    push_note(1, 2, 10, 1'b0, 1'b0, "mute_fx2");
    push_note(1, 3, 10, 1'b0, 1'b0, "mute_fx3");
    push_idle(2, 1'b1, "mute_done");
    run(1, 3'b010, 1'b0, 1'b1);
    run(12, 3'b000, 1'b0, 1'b1);
    run(30, 3'b000, 1'b1, 1'b1);

    // Reset mid-alarm with effect pending: nothing plays afterwards.
    push_idle(1, 1'b0, "rst_req");
    for (int a = 0; a < 3; a++) push_note(2, a, 10, 1'b0, 1'b1, "rst_alarm");
    push_note(2, 3, 3, 1'b0, 1'b1, "rst_alarm3");
    push_idle(1, 1'b0, "rst_applied");
    push_idle(20, 1'b0, "rst_after");
    run(1, 3'b100, 1'b0, 1'b1);
    run(32, 3'b000, 1'b0, 1'b1);
    run(1, 3'b010, 1'b0, 1'b1);
    run(1, 3'b000, 1'b0, 1'b0);
    run(20, 3'b000, 1'b0, 1'b1);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expectations unconsumed, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
